// File: rtl/decode_stage.sv
// RV32I decode stage: one registered entry between fetch and execute, with
// valid/ready on both sides, flush, and pass-through of illegal encodings.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_funct3,
    output logic            out_funct7,
    output logic [1:0]      out_op_sel,
    output logic            out_jal_r,
    output logic            out_lui,
    output logic            out_auipc,
    output logic            out_load,
    output logic            out_store,
    output logic            out_branch,
    output logic            out_reg_we,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7_field;
    logic [4:0] rd;

    assign opcode       = in_instr[6:0];
    assign funct3       = in_instr[14:12];
    assign funct7_field = in_instr[31:25];
    assign rd           = in_instr[11:7];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    logic [XLEN-1:0] d_imm;
    logic [1:0]      d_op_sel;
    logic            d_funct7, d_jal_r, d_lui, d_auipc, d_load, d_store;
    logic            d_branch, d_reg_we, d_legal;

    always_comb begin
        d_imm    = '0;
        d_op_sel = 2'b00;
        d_funct7 = 1'b0;
        d_jal_r  = 1'b0;
        d_lui    = 1'b0;
        d_auipc  = 1'b0;
        d_load   = 1'b0;
        d_store  = 1'b0;
        d_branch = 1'b0;
        d_reg_we = 1'b0;
        d_legal  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d_legal = 1'b1; d_lui = 1'b1; d_op_sel = 2'b10;
                d_reg_we = 1'b1; d_imm = imm_u;
            end
            OPC_AUIPC: begin
                d_legal = 1'b1; d_auipc = 1'b1; d_op_sel = 2'b11;
                d_reg_we = 1'b1; d_imm = imm_u;
            end
            OPC_JAL: begin
                d_legal = 1'b1; d_jal_r = 1'b1; d_op_sel = 2'b11;
                d_reg_we = 1'b1; d_imm = imm_j;
            end
            OPC_JALR: begin
                d_legal = (funct3 == 3'b000); d_jal_r = 1'b1; d_op_sel = 2'b10;
                d_reg_we = 1'b1; d_imm = imm_i;
            end
            OPC_BRANCH: begin
                d_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
                d_branch = 1'b1; d_imm = imm_b;
            end
            OPC_LOAD: begin
                d_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                d_load = 1'b1; d_op_sel = 2'b10; d_reg_we = 1'b1; d_imm = imm_i;
            end
            OPC_STORE: begin
                d_legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
                d_store = 1'b1; d_op_sel = 2'b10; d_imm = imm_s;
            end
            OPC_OPIMM: begin
                d_op_sel = 2'b10; d_reg_we = 1'b1; d_imm = imm_i;
                if (funct3 == 3'b001) begin
                    d_legal = (funct7_field == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    d_legal  = ({funct7_field[6], funct7_field[4:0]} == 6'b0);
                    d_funct7 = in_instr[30];
                end else begin
                    d_legal = 1'b1;
                end
            end
            OPC_OP: begin
                d_reg_we = 1'b1; d_funct7 = in_instr[30];
                d_legal  = (funct7_field == 7'b0000000) ||
                           ((funct7_field == 7'b0100000) &&
                            ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_FENCE: begin
                d_legal = 1'b1; d_imm = imm_i;
            end
            default: d_legal = 1'b0;
        endcase
        // Illegal words travel on to execute, but must not trigger any ALU/memory action
        if (!d_legal) begin
            d_op_sel = 2'b00;
            d_funct7 = 1'b0;
            d_jal_r  = 1'b0;
            d_lui    = 1'b0;
            d_auipc  = 1'b0;
            d_load   = 1'b0;
            d_store  = 1'b0;
            d_branch = 1'b0;
            d_reg_we = 1'b0;
        end
        if (rd == 5'd0) d_reg_we = 1'b0;
    end

    assign in_ready = !out_valid || out_ready;

    // Flush beats both the incoming transfer and the drain; other fields may go stale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_imm     <= '0;
            out_funct3  <= '0;
            out_funct7  <= 1'b0;
            out_op_sel  <= '0;
            out_jal_r   <= 1'b0;
            out_lui     <= 1'b0;
            out_auipc   <= 1'b0;
            out_load    <= 1'b0;
            out_store   <= 1'b0;
            out_branch  <= 1'b0;
            out_reg_we  <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_rs1     <= in_instr[19:15];
            out_rs2     <= in_instr[24:20];
            out_rd      <= rd;
            out_imm     <= d_imm;
            out_funct3  <= funct3;
            out_funct7  <= d_funct7;
            out_op_sel  <= d_op_sel;
            out_jal_r   <= d_jal_r;
            out_lui     <= d_lui;
            out_auipc   <= d_auipc;
            out_load    <= d_load;
            out_store   <= d_store;
            out_branch  <= d_branch;
            out_reg_we  <= d_reg_we;
            out_illegal <= !d_legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction decode stage that sits between fetch and the execute ALU.
- Accepts one instruction per cycle over a valid/ready handshake and decodes it into the ALU control set (funct3, funct7 bit, jal_r, lui, auipc, load, store, op_sel), register indices and the sign-extended immediate.
- Presents the decoded result, registered, to execute over a second valid/ready handshake.
- Supports pipeline flush and flags illegal encodings without dropping them.

Parameters:
- XLEN, 32, datapath width for instr, pc and imm. Only 32 is supported.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  32  PC of in_instr.
- flush  in  1  discard the held entry and the incoming transfer.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  execute accepts the entry.
- out_pc  out  32  registered PC.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  32  sign-extended immediate.
- out_funct3  out  3  instr[14:12].
- out_funct7  out  1  ALU alternate-op bit.
- out_op_sel  out  2  [0]: op1 = PC; [1]: op2 = imm (this bit drives the ALU has_imm input).
- out_jal_r, out_lui, out_auipc, out_load, out_store, out_branch  out  1 each  class flags.
- out_reg_we  out  1  write rd.
- out_illegal  out  1  illegal encoding.

Behaviour:
- Reset: every output register is cleared to 0. in_ready is combinational and therefore reads 1 after reset.
- Storage is a single entry.
- in_ready = !out_valid | out_ready. No combinational path from in_valid to in_ready.
- Transfer in: when in_valid & in_ready & !flush, the decoded fields load on the next edge and out_valid becomes 1. Latency is exactly 1 cycle.
- Drain: when out_valid & out_ready and no new transfer, out_valid becomes 0.
- Throughput is one instruction per cycle when out_ready is held at 1.
- Stall: while out_valid & !out_ready, all out_* fields hold stable.
- Flush has priority over everything else: on the next edge out_valid = 0 and the incoming instruction is dropped even if in_valid & in_ready. The remaining output fields may keep stale values.
- Reset asserted mid-operation clears out_valid immediately, regardless of the clock.
- Immediates follow the standard I/S/B/U/J formats, sign-extended from instr[31]. U-type is instr[31:12] followed by 12 zeros. R-type gives imm = 0.
- Decode by opcode (instr[6:0]):
  - LUI 0110111: lui=1, op_sel=10, reg_we=1.
  - AUIPC 0010111: auipc=1, op_sel=11, reg_we=1.
  - JAL 1101111: jal_r=1, op_sel=11, reg_we=1.
  - JALR 1100111 (funct3 must be 000): jal_r=1, op_sel=10, reg_we=1.
  - BRANCH 1100011: branch=1, op_sel=00, imm = B-type. funct3 010 and 011 are illegal.
  - LOAD 0000011: load=1, op_sel=10, reg_we=1. funct3 must be in {000,001,010,100,101}.
  - STORE 0100011: store=1, op_sel=10. funct3 must be in {000,001,010}.
  - OP-IMM 0010011: op_sel=10, reg_we=1. For funct3 001, instr[31:25] must be 0000000. For funct3 101, instr[31:25] must be 0000000 or 0100000, and funct7 = instr[30].
  - OP 0110011: op_sel=00, reg_we=1, funct7 = instr[30]. instr[31:25] must be 0000000, or 0100000 only with funct3 000 or 101.
  - FENCE 0001111: no-op with all flags 0.
- funct7 = 0 for every case not listed above.
- Anything else is illegal, including instr[1:0] != 11 and SYSTEM.
- An illegal entry is still passed through with out_valid = 1 and out_illegal = 1. All class flags, op_sel and reg_we are 0 for it.
- rd = x0 forces reg_we = 0.
- rs1/rs2/rd fields are always passed through raw: instr[19:15], [24:20], [11:7].

Test Plan:
- Reset, then in 0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, funct3=000, op_sel=10, reg_we=1, funct7=0.
- 0x402081B3 (sub x3,x1,x2) then 0x40325213 (srai x4,x4,3) back-to-back -> consecutive outputs:
  - sub: funct7=1, op_sel=00, rd=3.
  - srai: funct3=101, funct7=1, imm=0x403, op_sel=10.
- 0xFFDFF0EF (jal x1,-4) at pc 0x100 held with out_ready=0 for 3 cycles -> imm=0xFFFFFFFC, jal_r=1, op_sel=11, and all fields stable. in_ready=0 until out_ready=1; a second instruction is accepted in that same cycle.
- 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, lui=1, op_sel=10. 0x00000000 -> out_illegal=1, reg_we=0, out_valid=1.
- Entry held (out_ready=0) and flush=1 with in_valid=1 -> next cycle out_valid=0 and the incoming instruction is not seen.
- Reset pulsed between clock edges while out_valid=1 -> out_valid=0 immediately. Afterwards a new instruction decodes with 1-cycle latency.
